// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage RISC-32 pipeline.
// Consumes the OF_EX register fields, runs the ALU, updates the compare
// flags, resolves branches and registers the EX_MA fields.
// div/mod with a non-zero divisor run on an iterative restoring divider
// and hold the upstream stages through 'stall'.
//
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   in_valid                   OF_EX holds a real instruction
//   Instruction, pc_current    instruction word and its PC
//   BranchTarget               precomputed branch target
//   Op1, Op2, Immx             operand A, register operand B / store data, immediate
//   IsSt..IsCall, AluSignal    control bits and ALU operation select
//   stall                      hold OF_EX and everything upstream
//   ex_valid                   EX_MA outputs hold a real instruction
//   ALUResult, StoreData       registered ALU result and Op2
//   pc_out, Instruction_out    registered pass-through
//   IsSt_out..IsCall_out       registered control bits
//   BranchPC, IsBranchTaken    registered branch resolution
//   FlagE, FlagGT              compare flags
module ex_stage #(
  parameter int XLEN       = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            in_valid,
  input  logic [31:0]     Instruction,
  input  logic [XLEN-1:0] pc_current,
  input  logic [XLEN-1:0] BranchTarget,
  input  logic [XLEN-1:0] Op1,
  input  logic [XLEN-1:0] Op2,
  input  logic [XLEN-1:0] Immx,
  input  logic            IsSt,
  input  logic            IsLd,
  input  logic            IsBeq,
  input  logic            IsBgt,
  input  logic            IsRet,
  input  logic            IsImmediate,
  input  logic            IsWb,
  input  logic            IsUBranch,
  input  logic            IsCall,
  input  logic [4:0]      AluSignal,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ALUResult,
  output logic [XLEN-1:0] StoreData,
  output logic [XLEN-1:0] pc_out,
  output logic [31:0]     Instruction_out,
  output logic            IsSt_out,
  output logic            IsLd_out,
  output logic            IsWb_out,
  output logic            IsCall_out,
  output logic [XLEN-1:0] BranchPC,
  output logic            IsBranchTaken,
  output logic            FlagE,
  output logic            FlagGT
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(DIV_CYCLES - 1);

  typedef enum logic [4:0] {
    OP_ADD = 5'd0,
    OP_SUB = 5'd1,
    OP_CMP = 5'd2,
    OP_MUL = 5'd3,
    OP_DIV = 5'd4,
    OP_MOD = 5'd5,
    OP_AND = 5'd6,
    OP_OR  = 5'd7,
    OP_NOT = 5'd8,
    OP_MOV = 5'd9,
    OP_LSL = 5'd10,
    OP_LSR = 5'd11,
    OP_ASR = 5'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    DIV_BUSY,
    DIV_FIX
  } state_e;

  state_e state, state_next;

  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN-1:0] branch_pc;
  logic            taken;
  logic            is_divop;
  logic            div_start;
  logic            accept;

  // Divider state
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dq;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] drem;
  logic [XLEN:0]   shifted;
  logic            step_ok;
  logic [XLEN-1:0] rem_next;
  logic [XLEN-1:0] q_fix, r_fix;
  logic            d_neg_q, d_neg_r, d_mod;
  // The OF_EX register still holds the finished div in the cycle after the
  // fix edge (it was stalled through that edge); this flag makes the stage
  // ignore that stale copy instead of starting the same division again.
  logic            retire;

  // Fields captured at division start, released on the fix edge
  logic [XLEN-1:0] s_store, s_pc, s_bpc;
  logic [31:0]     s_instr;
  logic            s_st, s_ld, s_wb, s_call, s_taken;

  assign op_b      = IsImmediate ? Immx : Op2;
  assign abs_a     = Op1[XLEN-1] ? -Op1 : Op1;
  assign abs_b     = op_b[XLEN-1] ? -op_b : op_b;
  assign branch_pc = IsRet ? Op1 : BranchTarget;
  // Flags read here are the registered values from before this edge.
  assign taken     = IsUBranch | (IsBeq & FlagE) | (IsBgt & FlagGT);
  assign is_divop  = (AluSignal == OP_DIV) || (AluSignal == OP_MOD);
  assign div_start = (state == IDLE) && in_valid && !retire && is_divop && (op_b != '0);
  assign accept    = (state == IDLE) && in_valid && !retire && !div_start;

  assign shifted   = {drem, dq[XLEN-1]};
  assign step_ok   = shifted >= {1'b0, dvs};
  assign rem_next  = step_ok ? XLEN'(shifted - {1'b0, dvs}) : shifted[XLEN-1:0];
  assign q_fix     = d_neg_q ? -dq : dq;
  assign r_fix     = d_neg_r ? -drem : drem;

  always_comb begin
    alu_res = '0;
    case (AluSignal)
      OP_ADD:         alu_res = Op1 + op_b;
      OP_SUB, OP_CMP: alu_res = Op1 - op_b;
      OP_MUL:         alu_res = Op1 * op_b;
      OP_DIV:         alu_res = '1;   // reaches the outputs only for a zero divisor
      OP_MOD:         alu_res = Op1;  // likewise
      OP_AND:         alu_res = Op1 & op_b;
      OP_OR:          alu_res = Op1 | op_b;
      OP_NOT:         alu_res = ~op_b;
      OP_MOV:         alu_res = op_b;
      OP_LSL:         alu_res = Op1 << op_b[SHW-1:0];
      OP_LSR:         alu_res = Op1 >> op_b[SHW-1:0];
      OP_ASR:         alu_res = $signed(Op1) >>> op_b[SHW-1:0];
      default:        alu_res = '0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (div_start) state_next = DIV_BUSY;
      DIV_BUSY: if (cnt == LAST_STEP) state_next = DIV_FIX;
      DIV_FIX:  state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    stall = div_start || (state != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_valid        <= 1'b0;
      ALUResult       <= '0;
      StoreData       <= '0;
      pc_out          <= '0;
      Instruction_out <= '0;
      IsSt_out        <= 1'b0;
      IsLd_out        <= 1'b0;
      IsWb_out        <= 1'b0;
      IsCall_out      <= 1'b0;
      BranchPC        <= '0;
      IsBranchTaken   <= 1'b0;
      FlagE           <= 1'b0;
      FlagGT          <= 1'b0;
      cnt             <= '0;
      dq              <= '0;
      dvs             <= '0;
      drem            <= '0;
      d_neg_q         <= 1'b0;
      d_neg_r         <= 1'b0;
      d_mod           <= 1'b0;
      retire          <= 1'b0;
      s_store         <= '0;
      s_pc            <= '0;
      s_bpc           <= '0;
      s_instr         <= '0;
      s_st            <= 1'b0;
      s_ld            <= 1'b0;
      s_wb            <= 1'b0;
      s_call          <= 1'b0;
      s_taken         <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ex_valid        <= 1'b1;
            ALUResult       <= alu_res;
            StoreData       <= Op2;
            pc_out          <= pc_current;
            Instruction_out <= Instruction;
            IsSt_out        <= IsSt;
            IsLd_out        <= IsLd;
            IsWb_out        <= IsWb;
            IsCall_out      <= IsCall;
            BranchPC        <= branch_pc;
            IsBranchTaken   <= taken;
            if (AluSignal == OP_CMP) begin
              FlagE  <= (Op1 == op_b);
              FlagGT <= ($signed(Op1) > $signed(op_b));
            end
          end else begin
            // Bubble (including division start): control outputs drop, data holds.
            ex_valid      <= 1'b0;
            IsBranchTaken <= 1'b0;
            IsSt_out      <= 1'b0;
            IsLd_out      <= 1'b0;
            IsWb_out      <= 1'b0;
            IsCall_out    <= 1'b0;
          end
          if (div_start) begin
            cnt     <= '0;
            dq      <= abs_a;
            dvs     <= abs_b;
            drem    <= '0;
            d_neg_q <= Op1[XLEN-1] ^ op_b[XLEN-1];
            d_neg_r <= Op1[XLEN-1];
            d_mod   <= (AluSignal == OP_MOD);
            s_store <= Op2;
            s_pc    <= pc_current;
            s_bpc   <= branch_pc;
            s_instr <= Instruction;
            s_st    <= IsSt;
            s_ld    <= IsLd;
            s_wb    <= IsWb;
            s_call  <= IsCall;
            s_taken <= taken;
          end
        end
        DIV_BUSY: begin
          dq   <= {dq[XLEN-2:0], step_ok};
          drem <= rem_next;
          cnt  <= cnt + 1'b1;
        end
        DIV_FIX: begin
          ex_valid        <= 1'b1;
          ALUResult       <= d_mod ? r_fix : q_fix;
          StoreData       <= s_store;
          pc_out          <= s_pc;
          Instruction_out <= s_instr;
          IsSt_out        <= s_st;
          IsLd_out        <= s_ld;
          IsWb_out        <= s_wb;
          IsCall_out      <= s_call;
          BranchPC        <= s_bpc;
          IsBranchTaken   <= s_taken;
          retire          <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: table of vectors driven in order, expected
// EX_MA records queued at drive time and checked when ex_valid appears,
// plus hand-written reset, bubble and abort-division sequences.
module tb_ex_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        in_valid;
  logic [31:0] Instruction, pc_current, BranchTarget, Op1, Op2, Immx;
  logic        IsSt, IsLd, IsBeq, IsBgt, IsRet, IsImmediate, IsWb, IsUBranch, IsCall;
  logic [4:0]  AluSignal;
  logic        stall, ex_valid;
  logic [31:0] ALUResult, StoreData, pc_out, Instruction_out, BranchPC;
  logic        IsSt_out, IsLd_out, IsWb_out, IsCall_out, IsBranchTaken, FlagE, FlagGT;

  always #5 Clk = ~Clk;

  ex_stage #(.XLEN(32), .DIV_CYCLES(32)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid),
    .Instruction(Instruction), .pc_current(pc_current), .BranchTarget(BranchTarget),
    .Op1(Op1), .Op2(Op2), .Immx(Immx),
    .IsSt(IsSt), .IsLd(IsLd), .IsBeq(IsBeq), .IsBgt(IsBgt), .IsRet(IsRet),
    .IsImmediate(IsImmediate), .IsWb(IsWb), .IsUBranch(IsUBranch), .IsCall(IsCall),
    .AluSignal(AluSignal),
    .stall(stall), .ex_valid(ex_valid), .ALUResult(ALUResult), .StoreData(StoreData),
    .pc_out(pc_out), .Instruction_out(Instruction_out),
    .IsSt_out(IsSt_out), .IsLd_out(IsLd_out), .IsWb_out(IsWb_out), .IsCall_out(IsCall_out),
    .BranchPC(BranchPC), .IsBranchTaken(IsBranchTaken), .FlagE(FlagE), .FlagGT(FlagGT)
  );

  // br = {IsUBranch, IsBeq, IsBgt, IsRet}
  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b, imm;
    logic        isimm;
    logic [3:0]  br;
    logic [31:0] tgt, res, bpc;
    logic        taken, fe, fgt;
    int          stall_cyc;
  } vec_t;

  // ctl = {taken, st, ld, wb, call}
  typedef struct {
    logic [31:0] res, store, pc, instr, bpc;
    logic [4:0]  ctl;
    logic [1:0]  flags;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] op, input logic [31:0] a, b, imm,
                              input logic isimm, input logic [3:0] br,
                              input logic [31:0] tgt, res, bpc,
                              input logic taken, fe, fgt, input int st);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.imm = imm; v.isimm = isimm; v.br = br;
    v.tgt = tgt; v.res = res; v.bpc = bpc; v.taken = taken; v.fe = fe; v.fgt = fgt;
    v.stall_cyc = st;
    return v;
  endfunction

  // Result monitor: every ex_valid cycle must match the oldest queued record.
  always @(negedge Clk) begin
    if (!Reset && ex_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got ex_valid=1 ALUResult=0x%08h expected no pending result", ALUResult);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("alu@pc%0h", mon_e.pc), ALUResult, mon_e.res);
        check($sformatf("store@pc%0h", mon_e.pc), StoreData, mon_e.store);
        check($sformatf("pc@pc%0h", mon_e.pc), pc_out, mon_e.pc);
        check($sformatf("instr@pc%0h", mon_e.pc), Instruction_out, mon_e.instr);
        check($sformatf("bpc@pc%0h", mon_e.pc), BranchPC, mon_e.bpc);
        check($sformatf("ctl@pc%0h", mon_e.pc),
              {27'd0, IsBranchTaken, IsSt_out, IsLd_out, IsWb_out, IsCall_out}, {27'd0, mon_e.ctl});
        check($sformatf("flags@pc%0h", mon_e.pc), {30'd0, FlagE, FlagGT}, {30'd0, mon_e.flags});
      end
    end
  end

  // Drive one instruction, queue its expected record, hold it while stalled.
  task automatic drive(input vec_t v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [3:0] ctl, input string name);
    exp_t e;
    int   n;
    AluSignal = v.op; Op1 = v.a; Op2 = v.b; Immx = v.imm; IsImmediate = v.isimm;
    {IsUBranch, IsBeq, IsBgt, IsRet} = v.br;
    {IsSt, IsLd, IsWb, IsCall} = ctl;
    BranchTarget = v.tgt; pc_current = pc; Instruction = instr;
    in_valid = 1'b1;
    e.res = v.res; e.store = v.b; e.pc = pc; e.instr = instr; e.bpc = v.bpc;
    e.ctl = {v.taken, ctl}; e.flags = {v.fe, v.fgt};
    sb.push_back(e);
    n = 0;
    @(negedge Clk);
    while (stall && n < 100) begin
      n++;
      @(negedge Clk);
    end
    check({name, "_stall_cycles"}, n, v.stall_cyc);
    @(posedge Clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    //                op     a             b             imm     isimm br       tgt      res           bpc      tk fe fgt st
    tbl.push_back(mk(5'd0,  32'd5,        32'd7,        32'd0,  0, 4'b0000, 32'h0,   32'd12,       32'h0,   0, 0, 0, 0));
    tbl.push_back(mk(5'd2,  32'd3,        32'd3,        32'd0,  0, 4'b0000, 32'h0,   32'd0,        32'h0,   0, 1, 0, 0));
    tbl.push_back(mk(5'd0,  32'd0,        32'd0,        32'd0,  0, 4'b0100, 32'h100, 32'd0,        32'h100, 1, 1, 0, 0));
    tbl.push_back(mk(5'd1,  32'd10,       32'd3,        32'd0,  0, 4'b0000, 32'h0,   32'd7,        32'h0,   0, 1, 0, 0));
    tbl.push_back(mk(5'd2,  32'hFFFFFFFB, 32'd2,        32'd0,  0, 4'b0000, 32'h0,   32'hFFFFFFF9, 32'h0,   0, 0, 0, 0));
    tbl.push_back(mk(5'd9,  32'd0,        32'h99,       32'h1234, 1, 4'b0010, 32'h200, 32'h1234,   32'h200, 0, 0, 0, 0));
    tbl.push_back(mk(5'd2,  32'd7,        32'hFFFFFFFF, 32'd0,  0, 4'b0000, 32'h0,   32'd8,        32'h0,   0, 0, 1, 0));
    tbl.push_back(mk(5'd6,  32'hF0F0F0F0, 32'hFF00FF00, 32'd0,  0, 4'b0010, 32'h300, 32'hF000F000, 32'h300, 1, 0, 1, 0));
    tbl.push_back(mk(5'd7,  32'hF0F0F0F0, 32'h0F0F0000, 32'd0,  0, 4'b0000, 32'h0,   32'hFFFFF0F0, 32'h0,   0, 0, 1, 0));
    tbl.push_back(mk(5'd8,  32'h1234,     32'h0000FFFF, 32'd0,  0, 4'b0000, 32'h0,   32'hFFFF0000, 32'h0,   0, 0, 1, 0));
    tbl.push_back(mk(5'd3,  32'h10001,    32'h10001,    32'd0,  0, 4'b0000, 32'h0,   32'h00020001, 32'h0,   0, 0, 1, 0));
    tbl.push_back(mk(5'd10, 32'd1,        32'h55,       32'd31, 1, 4'b0000, 32'h0,   32'h80000000, 32'h0,   0, 0, 1, 0));
    tbl.push_back(mk(5'd11, 32'h80000000, 32'd4,        32'd0,  0, 4'b0000, 32'h0,   32'h08000000, 32'h0,   0, 0, 1, 0));
    tbl.push_back(mk(5'd12, 32'h80000000, 32'h77,       32'd4,  1, 4'b0000, 32'h0,   32'hF8000000, 32'h0,   0, 0, 1, 0));
    tbl.push_back(mk(5'd4,  32'd123,      32'd0,        32'd0,  0, 4'b0000, 32'h0,   32'hFFFFFFFF, 32'h0,   0, 0, 1, 0));
    tbl.push_back(mk(5'd5,  32'd123,      32'd0,        32'd0,  0, 4'b0000, 32'h0,   32'd123,      32'h0,   0, 0, 1, 0));
    tbl.push_back(mk(5'd13, 32'd5,        32'd6,        32'd0,  0, 4'b0000, 32'h0,   32'd0,        32'h0,   0, 0, 1, 0));
    tbl.push_back(mk(5'd4,  32'hFFFFFF9C, 32'd7,        32'd0,  0, 4'b0000, 32'h0,   32'hFFFFFFF2, 32'h0,   0, 0, 1, 34));
    tbl.push_back(mk(5'd5,  32'hFFFFFF9C, 32'd7,        32'd0,  0, 4'b0000, 32'h0,   32'hFFFFFFFE, 32'h0,   0, 0, 1, 34));
    tbl.push_back(mk(5'd4,  32'h80000000, 32'hFFFFFFFF, 32'd0,  0, 4'b0000, 32'h0,   32'h80000000, 32'h0,   0, 0, 1, 34));
    tbl.push_back(mk(5'd5,  32'h80000000, 32'hFFFFFFFF, 32'd0,  0, 4'b0000, 32'h0,   32'd0,        32'h0,   0, 0, 1, 34));
    tbl.push_back(mk(5'd4,  32'd100,      32'hFFFFFFF9, 32'd0,  0, 4'b0000, 32'h0,   32'hFFFFFFF2, 32'h0,   0, 0, 1, 34));
    tbl.push_back(mk(5'd5,  32'd100,      32'hFFFFFFF9, 32'd0,  0, 4'b0000, 32'h0,   32'd2,        32'h0,   0, 0, 1, 34));
    tbl.push_back(mk(5'd10, 32'd3,        32'd32,       32'd0,  0, 4'b0000, 32'h0,   32'd3,        32'h0,   0, 0, 1, 0));
    tbl.push_back(mk(5'd4,  32'd1000,     32'd0,        32'd10, 1, 4'b0000, 32'h0,   32'd100,      32'h0,   0, 0, 1, 34));

    // Reset with a valid add presented: nothing may be registered.
    Reset = 1'b1; in_valid = 1'b1; AluSignal = 5'd0; Op1 = 32'd5; Op2 = 32'd7; Immx = '0;
    Instruction = 32'hDEADBEEF; pc_current = 32'h40; BranchTarget = 32'h80;
    {IsSt, IsLd, IsBeq, IsBgt, IsRet, IsImmediate, IsWb, IsUBranch, IsCall} = '1;
    IsImmediate = 1'b0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("reset_alu", ALUResult, 32'd0);
    check("reset_pc", pc_out, 32'd0);
    check("reset_bpc", BranchPC, 32'd0);
    check("reset_ctl", {26'd0, IsBranchTaken, IsSt_out, IsLd_out, IsWb_out, IsCall_out, FlagE}, 32'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0; in_valid = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      drive(tbl[i], 32'h1000 + 32'(4 * i), {8'hA5, 24'(i)}, 4'(i), $sformatf("row%0d", i));

    // Return then an immediate bubble.
    v = mk(5'd0, 32'h2000, 32'd0, 32'd0, 0, 4'b1001, 32'h5555, 32'h2000, 32'h2000, 1, 0, 1, 0);
    drive(v, 32'h3000, 32'h12345678, 4'b0000, "ret");
    @(negedge Clk);
    @(negedge Clk);
    check("bubble_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("bubble_taken", {31'd0, IsBranchTaken}, 32'd0);
    check("bubble_alu_hold", ALUResult, 32'h2000);
    check("bubble_bpc_hold", BranchPC, 32'h2000);

    // Division aborted by reset after ten steps: no result may ever appear.
    @(posedge Clk);
    #1;
    AluSignal = 5'd4; Op1 = 32'hFFFFFF9C; Op2 = 32'd7; IsImmediate = 1'b0;
    {IsUBranch, IsBeq, IsBgt, IsRet} = '0;
    in_valid = 1'b1;
    repeat (5) @(negedge Clk);
    check("abort_busy_stall", {31'd0, stall}, 32'd1);
    repeat (7) @(posedge Clk);
    #1;
    Reset = 1'b1; in_valid = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("abort_alu", ALUResult, 32'd0);
    check("abort_store", StoreData, 32'd0);
    check("abort_instr", Instruction_out, 32'd0);
    check("abort_bpc", BranchPC, 32'd0);
    check("abort_flags", {30'd0, FlagE, FlagGT}, 32'd0);
    repeat (40) @(posedge Clk);
    #1;
    v = mk(5'd0, 32'd1, 32'd1, 32'd0, 0, 4'b0000, 32'h0, 32'd2, 32'h0, 0, 0, 0, 0);
    drive(v, 32'h4000, 32'h0BADF00D, 4'b0010, "post_abort_add");

    repeat (3) @(posedge Clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage RISC-32 pipeline. Sits directly downstream of the OF_EX pipeline register and consumes its fields: Instruction, pc_current, BranchTarget, Op1, Op2, Immx, the Is* control bits and AluSignal.
- Performs ALU operations, updates the compare flags and resolves branches.
- Registers its results into the EX_MA fields consumed by the memory-access stage.
- Divide and modulo are iterative and multi-cycle; the stage stalls upstream while they run.

Parameters:
- XLEN, 32, datapath width.
- DIV_CYCLES, 32, iteration count of the divider; must equal XLEN.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- in_valid  input  1  the OF_EX fields hold a real instruction.
- Instruction  input  32  instruction word.
- pc_current  input  32  PC of the instruction.
- BranchTarget  input  32  precomputed branch target.
- Op1  input  32  operand A.
- Op2  input  32  register operand B; also the store data.
- Immx  input  32  sign-extended immediate.
- IsSt, IsLd, IsBeq, IsBgt, IsRet, IsImmediate, IsWb, IsUBranch, IsCall  input  1 each  control bits.
- AluSignal  input  5  operation select.
- stall  output  1  hold the OF_EX register and everything upstream.
- ex_valid  output  1  EX_MA outputs hold a real instruction.
- ALUResult  output  32  registered ALU result.
- StoreData  output  32  registered Op2.
- pc_out, Instruction_out  output  32 each  registered pass-through.
- IsSt_out, IsLd_out, IsWb_out, IsCall_out  output  1 each  registered control bits.
- BranchPC  output  32  registered resolved target.
- IsBranchTaken  output  1  registered; high for one cycle per taken branch.
- FlagE, FlagGT  output  1 each  compare flags.

Behaviour:
- Reset, synchronous, overrides everything:
  - All outputs are 0.
  - FSM goes to IDLE and the iteration counter clears.
  - A division in progress is abandoned; no result is ever produced for it.
- Operand B is Immx if IsImmediate, else Op2.
- AluSignal encoding:
  - 0 add, 1 sub (A-B), 2 cmp (result A-B, updates flags).
  - 3 mul (low 32 bits of the product), 4 div (signed quotient), 5 mod (signed remainder).
  - 6 and, 7 or, 8 not (~B), 9 mov (B).
  - 10 lsl, 11 lsr, 12 asr; shift amount is B[4:0].
  - 13-31 give result 0.
- All arithmetic wraps modulo 2^32.
- Flags:
  - Only an accepted cmp writes them: FlagE = (A==B), FlagGT = signed A>B.
  - They are written on the acceptance edge and otherwise held.
- Branch resolution:
  - Uses the flag values held before the current edge, so a cmp immediately followed by beq is seen correctly.
  - taken = IsUBranch | (IsBeq & FlagE) | (IsBgt & FlagGT).
  - BranchPC = Op1 if IsRet, else BranchTarget.
- Single-cycle ops: in IDLE with in_valid=1, the rising edge registers all outputs; latency is 1 cycle and ex_valid=1 the following cycle.
- Bubbles: in IDLE with in_valid=0, ex_valid, IsBranchTaken and every Is*_out go to 0; data outputs hold.
- FSM states: IDLE, DIV_BUSY, DIV_FIX.
  - IDLE -> DIV_BUSY: in_valid & (op 4 or 5) & B!=0.
    - stall is asserted combinationally in that cycle.
    - The edge captures |A|, |B|, the signs, the op and the pass-through fields; ex_valid goes to 0.
  - DIV_BUSY: one restoring-division step per edge; stall=1; ex_valid=0; inputs are ignored.
  - DIV_BUSY -> DIV_FIX: after DIV_CYCLES steps.
  - DIV_FIX: stall=1. The edge applies the sign fix (quotient negative iff the operand signs differ; remainder takes the dividend sign), registers the outputs with ex_valid=1, and returns to IDLE.
  - Total: the result is visible after 34 edges, counting the acceptance edge as edge 1. stall is high for 34 cycles, falling to 0 in the cycle after the DIV_FIX edge.
- Divide by zero (B==0) is single-cycle with no stall: div gives 0xFFFFFFFF, mod gives A.
- Division overflow: 0x80000000 / -1 gives 0x80000000 and mod gives 0.
- Upstream keeps the OF_EX fields stable while stall=1; the stage never re-samples them mid-division.

Test Plan:
- Reset, then add with Op1=5, Op2=7 -> one cycle later ALUResult=12, ex_valid=1, stall never asserted.
- cmp with Op1=3, Op2=3, then beq with BranchTarget=0x100 on the next cycle -> FlagE=1, FlagGT=0, then IsBranchTaken=1 and BranchPC=0x100 for exactly one cycle.
- div with Op1=-100, Op2=7 -> stall high for 34 cycles, then ALUResult=0xFFFFFFF2 (-14); mod with the same operands -> 0xFFFFFFFE (-2).
- div with Op2=0 -> one cycle, ALUResult=0xFFFFFFFF, no stall; asr with Op1=0x80000000, Immx=4, IsImmediate=1 -> 0xF8000000.
- Reset asserted at division step 10 -> next cycle stall=0, ex_valid=0, all outputs 0; a following add of 1+1 gives 2 one cycle later.
- Ret with Op1=0x2000 and IsWb=0 -> BranchPC=0x2000, IsBranchTaken=1; a bubble (in_valid=0) immediately after -> ex_valid=0, IsBranchTaken=0.
